fetch_unit: RTL

//  Fetch/next-PC stage of the multicycle CPU. Holds the PC and instruction register (IR).

---
 rtl/cpu_defs_pkg.sv | 31 +++
 rtl/fetch_unit_next_pc_logic.sv | 45 ++++
 rtl/fetch_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the multicycle CPU.
// Holds the opcode/funct encodings used by the control FSM and the fetch
// stage, the instruction width, and the fetch-stage arm state encoding.
package cpu_defs;

  localparam int INSTR_W = 32;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Fetch-stage commit tracking: ARMED between IR load and PC commit.
  typedef enum logic {
    ARM_IDLE  = 1'b0,
    ARM_ARMED = 1'b1
  } arm_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
// Ports:
//   jump, beq, bne, alu_zero : FSM strobes and ALU zero flag
//   opcode                   : opcode of the instruction in IR
//   jump_index               : ir[25:0], J/JAL target field
//   imm_sext                 : sign-extended ir[15:0]
//   link_addr                : PC+4 of the instruction in IR
//   rs_data                  : JR target from the register file
//   next_pc                  : selected next PC
module next_pc_logic
  import cpu_defs::*;
(
  input  logic               jump,
  input  logic               beq,
  input  logic               bne,
  input  logic               alu_zero,
  input  logic [5:0]         opcode,
  input  logic [25:0]        jump_index,
  input  logic [INSTR_W-1:0] imm_sext,
  input  logic [INSTR_W-1:0] link_addr,
  input  logic [INSTR_W-1:0] rs_data,
  output logic [INSTR_W-1:0] next_pc
);

  logic               take_branch;
  logic [INSTR_W-1:0] branch_target;
  logic [INSTR_W-1:0] jump_target;

  // beq and bne together simply OR their conditions.
  assign take_branch   = (beq && alu_zero) || (bne && !alu_zero);
  assign branch_target = link_addr + {imm_sext[INSTR_W-3:0], 2'b00};
  assign jump_target   = {link_addr[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = link_addr;
    if (jump && opcode == OP_RTYPE) begin
      next_pc = rs_data;             // JR: passed through, never realigned
    end else if (jump) begin
      next_pc = jump_target;
    end else if (take_branch) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch/next-PC stage of the multicycle CPU.
// Holds PC, IR and the registered link address, decodes IR fields, and
// commits exactly one next-PC per loaded instruction even though the FSM
// holds pc_we high for several cycles.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   instr_we, pc_we      : FSM instrReg / PCReg strobes
//   jump, beq, bne       : FSM control-flow strobes
//   alu_zero, rs_data    : branch condition, JR target
//   imem_data/imem_addr  : instruction memory read data / address (= pc)
//   ir, opcode, funct,
//   rs, rt, rd, imm_sext : instruction register and its fields
//   link_addr            : PC+4 of the instruction in IR
//   pc_armed             : arm state (1 = IR loaded, PC not yet committed)
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] LINK_OFS = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_we,
  input  logic        pc_we,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] imm_sext,
  output logic [31:0] link_addr,
  output logic        pc_armed
);

  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [INSTR_W-1:0] link_q, link_d;
  arm_state_e         state_q, state_d;
  logic [INSTR_W-1:0] next_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      link_q  <= RESET_PC + LINK_OFS;
      state_q <= ARM_IDLE;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      link_q  <= link_d;
      state_q <= state_d;
    end
  end

  // An IR load always wins over a commit in the same cycle; the reload
  // recomputes link from the unchanged pc and keeps the stage armed.
  // pc_we while idle is ignored, so repeated PCReg cycles commit once.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    link_d  = link_q;
    state_d = state_q;
    if (instr_we) begin
      ir_d    = imem_data;
      link_d  = pc_q + LINK_OFS;
      state_d = ARM_ARMED;
    end else if (pc_we && state_q == ARM_ARMED) begin
      pc_d    = next_pc;
      state_d = ARM_IDLE;
    end
  end

  next_pc_logic u_next_pc (
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .alu_zero   (alu_zero),
    .opcode     (ir_q[31:26]),
    .jump_index (ir_q[25:0]),
    .imm_sext   (imm_sext),
    .link_addr  (link_q),
    .rs_data    (rs_data),
    .next_pc    (next_pc)
  );

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign opcode    = ir_q[31:26];
  assign funct     = ir_q[5:0];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign link_addr = link_q;
  assign pc_armed  = (state_q == ARM_ARMED);

endmodule
